axi2ahb_rdata_pack: RTL and testbench

Read-data return path of the AXI-to-AHB bridge, generalised so the AHB data bus can be narrower than the AXI bus (RATIO = AXI_DATA_WIDTH/AHB_DATA_WIDTH).
- Packs accepted AHB data-phase beats into AXI R beats, with lane placement driven by the bridge controller.
- Accumulates AHB two-cycle error responses per AXI beat, or sticky for the rest of the burst.
- Buffers finished beats in a parametrised FIFO that carries ID, RRESP and RLAST.
- Sits between the AHB master data phase and the AXI R channel, alongside the bridge controller.

---
 rtl/axi2ahb_pkg.sv | 19 +
 rtl/axi2ahb_rdata_pack_if.sv | 26 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/axi2ahb_rdata_pack.sv | 121 ++++++++++++
 tb/tb_axi2ahb_rdata_pack.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi2ahb_pkg.sv
// rtl/axi2ahb_pkg.sv - shared response codes and bus-ratio helpers for the AXI-to-AHB read path
package axi2ahb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int ratio_of(input int axi_w, input int ahb_w);
        return axi_w / ahb_w;
    endfunction

    // Legal when the AXI bus is a whole power-of-two multiple (1..8) of the AHB bus
    function automatic bit ratio_legal(input int axi_w, input int ahb_w);
        int r;
        if (ahb_w <= 0 || (axi_w % ahb_w) != 0) return 1'b0;
        r = axi_w / ahb_w;
        return (r == 1) || (r == 2) || (r == 4) || (r == 8);
    endfunction

endpackage

// File: rtl/axi2ahb_rdata_pack_if.sv
// rtl/axi2ahb_rdata_pack_if.sv - AXI R channel plus AHB data-phase signals seen by the read packer
interface axi2ahb_rdata_pack_if #(
    parameter int ID_W  = 1,
    parameter int AXI_W = 64,
    parameter int AHB_W = 32
);
    logic [ID_W-1:0]  RID;
    logic [AXI_W-1:0] RDATA;
    logic [1:0]       RRESP;
    logic             RLAST;
    logic             RVALID;
    logic             RREADY;
    logic [AHB_W-1:0] HRDATA;
    logic             HREADY;
    logic             HRESP;

    modport master (
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY, HRDATA, HREADY, HRESP
    );

    modport slave (
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY, HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, zeroed output when empty and drop flag
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          rd_en_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          empty_o,
    output logic                          drop_o,
    output logic [$clog2(DATA_DEPTH):0]   elem_cnt_o
);
    localparam int AW = $clog2(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_cnt;
    logic                  w_full;
    logic                  w_rd;
    logic                  w_wr;

    assign w_full  = (r_cnt == (AW+1)'(DATA_DEPTH));
    assign empty_o = (r_cnt == '0);
    assign w_rd    = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_wr    = wr_en_i && (!w_full || w_rd);
    assign drop_o  = wr_en_i && w_full && !w_rd;

    assign rd_data_o  = empty_o ? '0 : r_mem[r_rd_ptr];
    assign elem_cnt_o = r_cnt;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/axi2ahb_rdata_pack.sv
// rtl/axi2ahb_rdata_pack.sv - packs AHB read beats into AXI R beats with error accumulation and an R FIFO
module axi2ahb_rdata_pack
    import axi2ahb_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int ERR_MODE       = 0,
    localparam int RATIO  = ratio_of(AXI_DATA_WIDTH, AHB_DATA_WIDTH),
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1,
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi2ahb_rdata_pack_if.master    bus,
    input  logic [AXI_ID_WIDTH-1:0] cmd_id_i,
    input  logic                    cmd_error_i,
    input  logic                    ctrl_rdata_valid_i,
    input  logic [LANE_W-1:0]       ctrl_rdata_lane_i,
    input  logic                    ctrl_rdata_pack_end_i,
    input  logic                    ctrl_rdata_last_i,
    output logic                    ctrl_rdata_ready_o,
    output logic [LVL_W-1:0]        fifo_level_o,
    output logic                    overflow_o
);
    localparam int ENT_W = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3;

    if (!ratio_legal(AXI_DATA_WIDTH, AHB_DATA_WIDTH) || FIFO_DEPTH < 4 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("axi2ahb_rdata_pack: illegal bus ratio or FIFO depth");
    end

    logic [AXI_DATA_WIDTH-1:0] r_pack;
    logic                      r_acc_err;
    logic                      r_err_pend;
    logic                      r_sticky;
    logic                      r_overflow;

    logic [AXI_DATA_WIDTH-1:0] w_pack_merged;
    logic                      w_acc;
    logic                      w_push;
    logic                      w_beat_err;
    logic [1:0]                w_resp;
    logic [ENT_W-1:0]          w_push_data;
    logic [ENT_W-1:0]          w_rd_data;
    logic                      w_empty;
    logic                      w_drop;
    logic [LVL_W-1:0]          w_level;

    assign w_acc      = ctrl_rdata_valid_i && bus.HREADY;
    assign w_push     = w_acc && (ctrl_rdata_pack_end_i || ctrl_rdata_last_i || (RATIO == 1));
    assign w_beat_err = bus.HRESP || r_err_pend || cmd_error_i || ((ERR_MODE != 0) && r_sticky);
    assign w_resp     = (r_acc_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        w_pack_merged = r_pack;
        for (int i = 0; i < RATIO; i++) begin
            if (RATIO == 1 || ctrl_rdata_lane_i == LANE_W'(i)) begin
                w_pack_merged[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH] = bus.HRDATA;
            end
        end
    end

    assign w_push_data = {cmd_id_i, w_pack_merged, w_resp, ctrl_rdata_last_i};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_pack     <= '0;
            r_acc_err  <= 1'b0;
            r_err_pend <= 1'b0;
            r_sticky   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // First cycle of a two-cycle AHB error; folded into the beat that completes next
            if (w_acc) begin
                r_err_pend <= 1'b0;
            end else if (ctrl_rdata_valid_i && bus.HRESP && !bus.HREADY) begin
                r_err_pend <= 1'b1;
            end
            if (w_acc) begin
                if (w_push) begin
                    r_pack    <= '0;
                    r_acc_err <= 1'b0;
                end else begin
                    r_pack    <= w_pack_merged;
                    r_acc_err <= r_acc_err || w_beat_err;
                end
                if (ERR_MODE != 0) begin
                    r_sticky <= ctrl_rdata_last_i ? 1'b0 : (r_sticky || w_beat_err);
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (ENT_W),
        .DATA_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (ACLK),
        .rst        (ARESET),
        .wr_en_i    (w_push),
        .wr_data_i  (w_push_data),
        .rd_en_i    (bus.RREADY),
        .rd_data_o  (w_rd_data),
        .empty_o    (w_empty),
        .drop_o     (w_drop),
        .elem_cnt_o (w_level)
    );

    assign {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST} = w_rd_data;
    assign bus.RVALID = !w_empty;

    assign fifo_level_o = w_level;
    assign overflow_o   = r_overflow;
    // Keeps one slot free for the data phase already issued when ready drops
    assign ctrl_rdata_ready_o = !ARESET && ((FIFO_DEPTH - int'(w_level)) >= 2);
endmodule

// File: tb/tb_axi2ahb_rdata_pack.sv
// tb/tb_axi2ahb_rdata_pack.sv - scoreboard bench for the AXI read-data packer, both error modes side by side
module tb_axi2ahb_rdata_pack;
    import axi2ahb_pkg::*;

    typedef logic [67:0] ent_t;

    logic        clk = 1'b0;
    logic        arst;
    logic        rready;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [0:0]  cmd_id;
    logic        cmd_err;
    logic        v;
    logic [0:0]  lane;
    logic        pend;
    logic        last;
    logic        rdy0, rdy1, ovf0, ovf1;
    logic [2:0]  lvl0, lvl1;

    int   n_checks = 0;
    int   n_errs   = 0;
    ent_t q0[$];
    ent_t q1[$];

    always #5 clk = ~clk;

    axi2ahb_rdata_pack_if #(.ID_W(1), .AXI_W(64), .AHB_W(32)) bus0 ();
    axi2ahb_rdata_pack_if #(.ID_W(1), .AXI_W(64), .AHB_W(32)) bus1 ();

    assign bus0.RREADY = rready;
    assign bus0.HRDATA = hrdata;
    assign bus0.HREADY = hready;
    assign bus0.HRESP  = hresp;
    assign bus1.RREADY = rready;
    assign bus1.HRDATA = hrdata;
    assign bus1.HREADY = hready;
    assign bus1.HRESP  = hresp;

    axi2ahb_rdata_pack #(.AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(64), .AHB_DATA_WIDTH(32),
                         .FIFO_DEPTH(4), .ERR_MODE(0)) dut0 (
        .ACLK(clk), .ARESET(arst), .bus(bus0.master),
        .cmd_id_i(cmd_id), .cmd_error_i(cmd_err), .ctrl_rdata_valid_i(v),
        .ctrl_rdata_lane_i(lane), .ctrl_rdata_pack_end_i(pend), .ctrl_rdata_last_i(last),
        .ctrl_rdata_ready_o(rdy0), .fifo_level_o(lvl0), .overflow_o(ovf0)
    );

    axi2ahb_rdata_pack #(.AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(64), .AHB_DATA_WIDTH(32),
                         .FIFO_DEPTH(4), .ERR_MODE(1)) dut1 (
        .ACLK(clk), .ARESET(arst), .bus(bus1.master),
        .cmd_id_i(cmd_id), .cmd_error_i(cmd_err), .ctrl_rdata_valid_i(v),
        .ctrl_rdata_lane_i(lane), .ctrl_rdata_pack_end_i(pend), .ctrl_rdata_last_i(last),
        .ctrl_rdata_ready_o(rdy1), .fifo_level_o(lvl1), .overflow_o(ovf1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic id, input logic [63:0] d, input logic [1:0] rs, input logic ls);
        return {id, d, rs, ls};
    endfunction

    task automatic push_exp(input ent_t e0, input ent_t e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic beat(input logic [31:0] d, input logic ln, input logic pe, input logic ls,
                        input logic id, input logic hr, input logic ce);
        v = 1'b1; hready = 1'b1; hrdata = d; lane = ln; pend = pe; last = ls;
        cmd_id = id; hresp = hr; cmd_err = ce;
        @(posedge clk); #1;
        v = 1'b0; hresp = 1'b0; cmd_err = 1'b0; pend = 1'b0; last = 1'b0;
    endtask

    task automatic err_wait();
        v = 1'b1; hready = 1'b0; hresp = 1'b1;
        @(posedge clk); #1;
        v = 1'b0; hready = 1'b1; hresp = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        check(name, q0.size() + q1.size(), 0);
    endtask

    // Scoreboard monitor: every R handshake is matched against the head of its queue
    always @(negedge clk) begin
        if (!arst && rready) begin
            if (bus0.RVALID) begin
                if (q0.size() == 0) begin
                    n_checks++; n_errs++;
                    $display("FAIL dut0 unexpected R beat: got %0h, none required",
                             {bus0.RID, bus0.RDATA, bus0.RRESP, bus0.RLAST});
                end else begin
                    check("dut0 R beat", {bus0.RID, bus0.RDATA, bus0.RRESP, bus0.RLAST}, q0.pop_front());
                end
            end
            if (bus1.RVALID) begin
                if (q1.size() == 0) begin
                    n_checks++; n_errs++;
                    $display("FAIL dut1 unexpected R beat: got %0h, none required",
                             {bus1.RID, bus1.RDATA, bus1.RRESP, bus1.RLAST});
                end else begin
                    check("dut1 R beat", {bus1.RID, bus1.RDATA, bus1.RRESP, bus1.RLAST}, q1.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1; rready = 1'b0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        cmd_id = '0; cmd_err = 1'b0; v = 1'b0; lane = '0; pend = 1'b0; last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", {rdy0, rdy1}, 2'b00);
        check("reset rvalid", {bus0.RVALID, bus1.RVALID}, 2'b00);
        check("reset level", {lvl0, lvl1}, 6'd0);
        check("reset overflow", {ovf0, ovf1}, 2'b00);
        check("reset r fields", {bus0.RID, bus0.RDATA, bus0.RRESP, bus0.RLAST}, 68'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        check("ready after reset", {rdy0, rdy1}, 2'b11);
        check("rvalid after reset", {bus0.RVALID, bus1.RVALID}, 2'b00);

        // Two-lane pack with first-word latency
        rready = 1'b1;
        @(posedge clk); #1;
        push_exp(mk(1, 64'h22222222_11111111, RESP_OKAY, 1), mk(1, 64'h22222222_11111111, RESP_OKAY, 1));
        beat(32'h11111111, 0, 0, 0, 1, 0, 0);
        beat(32'h22222222, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        check("first word latency", {bus0.RVALID, bus1.RVALID}, 2'b11);
        wait_drain("drain pack");

        // Narrow beat, last alone closes the AXI beat
        push_exp(mk(0, 64'hAABBCCDD_00000000, RESP_OKAY, 1), mk(0, 64'hAABBCCDD_00000000, RESP_OKAY, 1));
        beat(32'hAABBCCDD, 1, 0, 1, 0, 0, 0);
        wait_drain("drain narrow");

        // Two-cycle AHB error on AXI beat 1 of a 4-beat burst
        for (int k = 0; k < 4; k++) begin
            push_exp(mk(1, {32'h20000000 + 32'(k), 32'h10000000 + 32'(k)},
                        (k == 1) ? RESP_SLVERR : RESP_OKAY, k == 3),
                     mk(1, {32'h20000000 + 32'(k), 32'h10000000 + 32'(k)},
                        (k >= 1) ? RESP_SLVERR : RESP_OKAY, k == 3));
            if (k == 1) begin
                err_wait();
                beat(32'h10000000 + 32'(k), 0, 0, 0, 1, 1, 0);
            end else begin
                beat(32'h10000000 + 32'(k), 0, 0, 0, 1, 0, 0);
            end
            beat(32'h20000000 + 32'(k), 1, 1, k == 3, 1, 0, 0);
        end
        push_exp(mk(0, 64'h44444444_33333333, RESP_OKAY, 1), mk(0, 64'h44444444_33333333, RESP_OKAY, 1));
        beat(32'h33333333, 0, 0, 0, 0, 0, 0);
        beat(32'h44444444, 1, 1, 1, 0, 0, 0);
        wait_drain("drain error burst");

        // Error signalling while no data phase is active must be ignored
        hready = 1'b0; hresp = 1'b1;
        @(posedge clk); #1;
        hready = 1'b1;
        @(posedge clk); #1;
        hresp = 1'b0;
        push_exp(mk(1, 64'h00000000_5A5A5A5A, RESP_OKAY, 1), mk(1, 64'h00000000_5A5A5A5A, RESP_OKAY, 1));
        beat(32'h5A5A5A5A, 0, 1, 1, 1, 0, 0);
        push_exp(mk(0, 64'h66666666_00000000, RESP_SLVERR, 1), mk(0, 64'h66666666_00000000, RESP_SLVERR, 1));
        beat(32'h66666666, 1, 1, 1, 0, 0, 1);
        wait_drain("drain idle error");

        // Backpressure: ready falls at level 3, fifth push overflows
        rready = 1'b0;
        @(negedge clk);
        check("bp ready empty", {rdy0, rdy1}, 2'b11);
        for (int k = 0; k < 4; k++) begin
            push_exp(mk(k[0], {32'h0, 32'hB0000000 + 32'(k)}, RESP_OKAY, 1),
                     mk(k[0], {32'h0, 32'hB0000000 + 32'(k)}, RESP_OKAY, 1));
            beat(32'hB0000000 + 32'(k), 0, 1, 1, k[0], 0, 0);
            @(negedge clk);
            check("bp level", {lvl0, lvl1}, {3'(k + 1), 3'(k + 1)});
            check("bp ready", {rdy0, rdy1}, (k + 1 <= 2) ? 2'b11 : 2'b00);
            check("bp overflow", {ovf0, ovf1}, 2'b00);
        end
        beat(32'hBEEFBEEF, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("overflow set", {ovf0, ovf1}, 2'b11);
        check("overflow level", {lvl0, lvl1}, {3'd4, 3'd4});
        check("stable under stall", {bus0.RID, bus0.RDATA, bus0.RRESP, bus0.RLAST},
              mk(0, 64'h00000000_B0000000, RESP_OKAY, 1));
        @(posedge clk); #1;
        rready = 1'b1;
        wait_drain("drain backpressure");
        check("level after drain", {lvl0, lvl1}, 6'd0);
        check("overflow sticky", {ovf0, ovf1}, 2'b11);

        // Reset mid-pack with two entries buffered
        rready = 1'b0;
        @(posedge clk); #1;
        beat(32'hC0000000, 0, 1, 1, 0, 0, 0);
        beat(32'hC0000001, 0, 1, 1, 0, 0, 0);
        beat(32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("pre-reset level", {lvl0, lvl1}, {3'd2, 3'd2});
        arst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        check("mid reset rvalid", {bus0.RVALID, bus1.RVALID}, 2'b00);
        check("mid reset level", {lvl0, lvl1}, 6'd0);
        check("mid reset overflow", {ovf0, ovf1}, 2'b00);
        check("mid reset ready", {rdy0, rdy1}, 2'b11);
        rready = 1'b1;
        push_exp(mk(0, 64'h00000055_00000000, RESP_OKAY, 1), mk(0, 64'h00000055_00000000, RESP_OKAY, 1));
        beat(32'h00000055, 1, 0, 1, 0, 0, 0);
        wait_drain("drain after reset");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
